// File: rtl/wb_burst_mem_responder.sv
// wb_burst_mem_responder
// Wishbone responder that serves single reads/writes and 4-/8-beat read bursts.
// Each beat becomes one req/gnt transfer on the backing-memory port; reads then
// wait for the in-order rvalid return. Ack and err are one-cycle pulses.
module wb_burst_mem_responder #(
  parameter int ADDR_W    = 24,
  parameter int DATA_W    = 16,
  parameter int MEM_WORDS = 2**20
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                wb_cyc,
  input  logic                wb_stb,
  input  logic                wb_we,
  input  logic [ADDR_W-1:0]   wb_adr,
  input  logic [DATA_W-1:0]   wb_i_dat,
  input  logic [DATA_W/8-1:0] wb_sel,
  input  logic                wb_4_burst,
  input  logic                wb_8_burst,
  output logic [DATA_W-1:0]   wb_o_dat,
  output logic                wb_ack,
  output logic                wb_err,
  output logic                wb_rty,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_gnt,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_ACK   = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  // Range limit widened by one bit so adr+N-1 can never wrap past it.
  localparam logic [ADDR_W:0] MEM_LIMIT = (ADDR_W+1)'(MEM_WORDS);

  state_t              state_reg, state_next;
  logic [2:0]          beat_reg, beat_next;
  logic [2:0]          len_m1_reg, len_m1_next;
  logic [ADDR_W-1:0]   base_reg, base_next;
  logic                err_reg, err_next;
  logic [DATA_W-1:0]   rdata_reg, rdata_next;

  logic [2:0]          req_len_m1;
  logic [ADDR_W:0]     last_addr;
  logic                start;
  logic                bad_req;

  // Decode the request presented on the bus: length, last beat address, legality.
  // Sampling is suppressed during the err pulse so the same strobe is not judged twice.
  always_comb begin
    req_len_m1 = wb_8_burst ? 3'd7 : (wb_4_burst ? 3'd3 : 3'd0);
    last_addr  = {1'b0, wb_adr} + {{(ADDR_W-2){1'b0}}, req_len_m1};
    start      = wb_cyc & wb_stb & ~err_reg;
    bad_req    = (wb_we & (wb_4_burst | wb_8_burst)) | (last_addr >= MEM_LIMIT);
  end

  // State and datapath registers; asynchronous reset drops any transfer at once.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg  <= S_IDLE;
      beat_reg   <= 3'd0;
      len_m1_reg <= 3'd0;
      base_reg   <= '0;
      err_reg    <= 1'b0;
      rdata_reg  <= '0;
    end else begin
      state_reg  <= state_next;
      beat_reg   <= beat_next;
      len_m1_reg <= len_m1_next;
      base_reg   <= base_next;
      err_reg    <= err_next;
      rdata_reg  <= rdata_next;
    end
  end

  // Next-state logic: beat sequencing, handshakes, aborts and error detection.
  always_comb begin
    state_next  = state_reg;
    beat_next   = beat_reg;
    len_m1_next = len_m1_reg;
    base_next   = base_reg;
    err_next    = 1'b0;
    rdata_next  = rdata_reg;
    unique case (state_reg)
      S_IDLE: begin
        if (start) begin
          if (bad_req) begin
            err_next = 1'b1;
          end else begin
            state_next  = S_REQ;
            len_m1_next = req_len_m1;
            base_next   = wb_adr;
            beat_next   = 3'd0;
          end
        end
      end
      S_REQ: begin
        if (!wb_cyc) begin
          state_next = S_IDLE;
        end else if (mem_gnt) begin
          state_next = wb_we ? S_ACK : S_WAIT;
        end
      end
      S_WAIT: begin
        // A granted read must still be retired even if the master walked away.
        if (!wb_cyc) begin
          state_next = mem_rvalid ? S_IDLE : S_DRAIN;
        end else if (mem_rvalid) begin
          rdata_next = mem_rdata;
          state_next = S_ACK;
        end
      end
      S_ACK: begin
        if (!wb_cyc || (beat_reg == len_m1_reg)) begin
          state_next = S_IDLE;
        end else begin
          beat_next  = beat_reg + 3'd1;
          state_next = S_REQ;
        end
      end
      S_DRAIN: begin
        if (mem_rvalid) begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Output decode; the memory request is withdrawn as soon as cyc drops.
  always_comb begin
    wb_ack    = (state_reg == S_ACK);
    wb_err    = err_reg;
    wb_rty    = 1'b0;
    wb_o_dat  = rdata_reg;
    mem_req   = (state_reg == S_REQ) & wb_cyc;
    mem_we    = mem_req & wb_we;
    mem_addr  = mem_req ? (base_reg + ADDR_W'(beat_reg)) : '0;
    mem_wdata = mem_we ? wb_i_dat : '0;
    mem_wmask = mem_req ? wb_sel : '0;
  end

endmodule

// File: tb/tb_wb_burst_mem_responder.sv
// Testbench for wb_burst_mem_responder: directed vector table, hand-written
// abort/reset sequences and randomized transactions against a transaction-level model.
`timescale 1ns/1ps
module tb_wb_burst_mem_responder;

  localparam int ADDR_W    = 24;
  localparam int DATA_W    = 16;
  localparam int MEM_WORDS = 2**20;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wb_cyc, wb_stb, wb_we, wb_4_burst, wb_8_burst;
  logic [23:0] wb_adr;
  logic [15:0] wb_i_dat, wb_o_dat;
  logic [1:0]  wb_sel;
  logic        wb_ack, wb_err, wb_rty;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [23:0] mem_addr;
  logic [15:0] mem_wdata, mem_rdata;
  logic [1:0]  mem_wmask;

  always #5 clk = ~clk;

  wb_burst_mem_responder #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_WORDS(MEM_WORDS)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_adr(wb_adr),
    .wb_i_dat(wb_i_dat), .wb_sel(wb_sel), .wb_4_burst(wb_4_burst), .wb_8_burst(wb_8_burst),
    .wb_o_dat(wb_o_dat), .wb_ack(wb_ack), .wb_err(wb_err), .wb_rty(wb_rty),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  int total = 0;
  int bad   = 0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // ---------------- backend memory model ----------------
  typedef struct { longint unsigned addr; int cnt; } rd_t;
  rd_t               rq[$];
  logic [15:0]       bmem [longint unsigned];
  logic [15:0]       ref_mem [longint unsigned];
  longint unsigned   mem_log[$];
  int                gnt_wait_max = 0;
  int                rv_min = 1;
  int                rv_max = 1;
  logic              gp = 1'b0;
  logic              gp_we;
  longint unsigned   gp_addr;
  logic [15:0]       gp_wdata;
  logic [1:0]        gp_wmask;
  logic [15:0]       be_w;

  // Unwritten words read back as the low bits of their address.
  function automatic logic [15:0] be_read(input longint unsigned a);
    if (bmem.exists(a)) return bmem[a];
    return a[15:0];
  endfunction

  function automatic logic [15:0] ref_read(input longint unsigned a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return a[15:0];
  endfunction

  function automatic void ref_write(input longint unsigned a, input logic [15:0] d, input logic [1:0] s);
    logic [15:0] w;
    w = ref_read(a);
    if (s[0]) w[7:0]  = d[7:0];
    if (s[1]) w[15:8] = d[15:8];
    ref_mem[a] = w;
  endfunction

  initial begin
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    forever begin
      @(posedge clk); #2;
      if (!rst_n) begin
        rq.delete(); gp = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
      end else begin
        if (mem_rvalid && rq.size() > 0) rq.delete(0);
        if (gp) begin
          mem_log.push_back(gp_addr);
          if (gp_we) begin
            be_w = be_read(gp_addr);
            if (gp_wmask[0]) be_w[7:0]  = gp_wdata[7:0];
            if (gp_wmask[1]) be_w[15:8] = gp_wdata[15:8];
            bmem[gp_addr] = be_w;
          end else begin
            rq.push_back('{addr: gp_addr, cnt: int'($urandom_range(rv_max, rv_min))});
          end
        end
        mem_rvalid = 1'b0;
        if (rq.size() > 0) begin
          if (rq[0].cnt <= 1) begin
            mem_rvalid = 1'b1;
            mem_rdata  = be_read(rq[0].addr);
          end else begin
            rq[0].cnt = rq[0].cnt - 1;
          end
        end
        gp = mem_req && ($urandom_range(gnt_wait_max, 0) == 0);
        mem_gnt = gp;
        if (gp) begin
          gp_we = mem_we; gp_addr = mem_addr; gp_wdata = mem_wdata; gp_wmask = mem_wmask;
        end
      end
    end
  end

  // ---------------- bus master ----------------
  logic [15:0] got_data[$];
  int          n_ack, first_ack_cyc, ack_seen;
  logic        got_err, timed_out;

  task automatic idle_bus();
    wb_cyc = 0; wb_stb = 0; wb_we = 0; wb_adr = '0; wb_i_dat = '0;
    wb_sel = '0; wb_4_burst = 0; wb_8_burst = 0;
  endtask

  task automatic run_txn(input logic we, input logic [23:0] adr, input logic [15:0] dat,
                         input logic [1:0] sel, input logic b4, input logic b8);
    int n;
    int cyc_i;
    n = b8 ? 8 : (b4 ? 4 : 1);
    got_data.delete(); mem_log.delete();
    n_ack = 0; got_err = 0; timed_out = 0; first_ack_cyc = -1;
    @(posedge clk); #1;
    wb_cyc = 1; wb_stb = 1; wb_we = we; wb_adr = adr; wb_i_dat = dat;
    wb_sel = sel; wb_4_burst = b4; wb_8_burst = b8;
    cyc_i = 0;
    forever begin
      #2;
      if (wb_ack) begin
        if (n_ack == 0) first_ack_cyc = cyc_i;
        n_ack++;
        got_data.push_back(wb_o_dat);
      end
      if (wb_err) got_err = 1;
      if (got_err || n_ack >= n) break;
      if (cyc_i >= 300) begin timed_out = 1; break; end
      @(posedge clk); #1;
      cyc_i++;
    end
    @(posedge clk); #1;
    idle_bus();
    #2;
    check("post_ack", wb_ack, 0);
    check("post_err", wb_err, 0);
  endtask

  // Runs one transaction and checks it against the transaction-level model.
  task automatic check_txn(input logic we, input logic [23:0] adr, input logic [15:0] dat,
                           input logic [1:0] sel, input logic b4, input logic b8);
    int n;
    int exp_n;
    logic exp_err;
    longint unsigned a;
    n = b8 ? 8 : (b4 ? 4 : 1);
    a = adr;
    exp_err = (we && (b4 || b8)) || (a + longint'(n) - 1 >= longint'(MEM_WORDS));
    exp_n = exp_err ? 0 : (we ? 1 : n);
    run_txn(we, adr, dat, sel, b4, b8);
    check("timeout", timed_out, 0);
    check("err", got_err, exp_err);
    check("acks", n_ack, exp_n);
    check("mem_reqs", mem_log.size(), exp_n);
    for (int i = 0; i < mem_log.size() && i < n; i++)
      check("mem_addr", mem_log[i], a + longint'(i));
    if (!exp_err) begin
      if (we) ref_write(a, dat, sel);
      else for (int i = 0; i < n && i < got_data.size(); i++)
        check("rdata", got_data[i], ref_read(a + longint'(i)));
    end
    $display("txn we=%0b adr=%06h dat=%04h sel=%02b b4=%0b b8=%0b acks=%0d err=%0b d0=%04h",
             we, adr, dat, sel, b4, b8, n_ack, got_err, (got_data.size() > 0) ? got_data[0] : 16'h0);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic we; logic [23:0] adr; logic [15:0] dat; logic [1:0] sel; logic b4; logic b8;
    logic exp_err; int exp_acks; logic [15:0] exp_d0; int exp_lat; int gnt_w; int rv;
  } vec_t;
  vec_t vecs [15];

  logic        r_we, r_b4, r_b8;
  logic [23:0] r_adr;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=running want=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    //            we adr         dat      sel    b4 b8 err acks d0       lat gw rv
    vecs[0]  = '{1, 24'h000010, 16'hBEEF, 2'b11, 0, 0, 0, 1, 16'h0000, 2, 0, 1};
    vecs[1]  = '{0, 24'h000010, 16'h0000, 2'b11, 0, 0, 0, 1, 16'hBEEF, 4, 0, 2};
    vecs[2]  = '{0, 24'h000100, 16'h0000, 2'b11, 0, 1, 0, 8, 16'h0100, 3, 0, 1};
    vecs[3]  = '{1, 24'h000100, 16'h1111, 2'b11, 1, 0, 1, 0, 16'h0000, -1, 0, 1};
    vecs[4]  = '{0, 24'h0FFFFE, 16'h0000, 2'b11, 1, 0, 1, 0, 16'h0000, -1, 0, 1};
    vecs[5]  = '{0, 24'h0FFFFC, 16'h0000, 2'b11, 1, 0, 0, 4, 16'hFFFC, -1, 0, 1};
    vecs[6]  = '{0, 24'h0FFFFF, 16'h0000, 2'b11, 0, 0, 0, 1, 16'hFFFF, -1, 1, 2};
    vecs[7]  = '{0, 24'h100000, 16'h0000, 2'b11, 0, 0, 1, 0, 16'h0000, -1, 0, 1};
    vecs[8]  = '{1, 24'h000020, 16'h1234, 2'b01, 0, 0, 0, 1, 16'h0000, -1, 2, 1};
    vecs[9]  = '{0, 24'h000020, 16'h0000, 2'b11, 0, 0, 0, 1, 16'h0034, -1, 0, 3};
    vecs[10] = '{0, 24'h000200, 16'h0000, 2'b11, 1, 1, 0, 8, 16'h0200, -1, 1, 2};
    vecs[11] = '{0, 24'h0FFFF9, 16'h0000, 2'b11, 0, 1, 1, 0, 16'h0000, -1, 0, 1};
    vecs[12] = '{0, 24'hFFFFFF, 16'h0000, 2'b11, 0, 1, 1, 0, 16'h0000, -1, 0, 1};
    vecs[13] = '{0, 24'h0FFFF8, 16'h0000, 2'b11, 0, 1, 0, 8, 16'hFFF8, -1, 2, 3};
    vecs[14] = '{1, 24'h0FFFFF, 16'hA5A5, 2'b10, 0, 0, 0, 1, 16'h0000, -1, 0, 1};

    idle_bus();
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", wb_ack, 0);
    check("rst_err", wb_err, 0);
    check("rst_rty", wb_rty, 0);
    check("rst_req", mem_req, 0);
    check("rst_odat", wb_o_dat, 0);
    check("rst_maddr", mem_addr, 0);
    rst_n = 1;
    @(posedge clk); #3;
    check("idle_ack", wb_ack, 0);
    check("idle_req", mem_req, 0);

    for (int v = 0; v < 15; v++) begin
      gnt_wait_max = vecs[v].gnt_w; rv_min = vecs[v].rv; rv_max = vecs[v].rv;
      check_txn(vecs[v].we, vecs[v].adr, vecs[v].dat, vecs[v].sel, vecs[v].b4, vecs[v].b8);
      check("vec_err", got_err, vecs[v].exp_err);
      check("vec_acks", n_ack, vecs[v].exp_acks);
      if (!vecs[v].we && got_data.size() > 0) check("vec_d0", got_data[0], vecs[v].exp_d0);
      if (vecs[v].exp_lat >= 0) check("vec_lat", first_ack_cyc, vecs[v].exp_lat);
    end

    // Abort: drop cyc while the 4th read of an 8-burst is outstanding.
    gnt_wait_max = 0; rv_min = 1; rv_max = 1;
    mem_log.delete(); n_ack = 0;
    @(posedge clk); #1;
    wb_cyc = 1; wb_stb = 1; wb_adr = 24'h000400; wb_8_burst = 1;
    for (int c = 0; c < 60 && n_ack < 3; c++) begin
      #2;
      if (wb_ack) n_ack++;
      if (n_ack < 3) begin @(posedge clk); #1; end
    end
    check("abort_3acks", n_ack, 3);
    rv_min = 4; rv_max = 4;
    @(posedge clk); #1;          // 4th beat requested and granted
    @(posedge clk); #1;          // waiting for its data
    idle_bus();
    ack_seen = 0;
    for (int c = 0; c < 2; c++) begin
      #2;
      if (wb_ack) ack_seen++;
      @(posedge clk); #1;
    end
    check("abort_no_ack", ack_seen, 0);
    check("abort_grants", mem_log.size(), 4);
    rv_min = 1; rv_max = 1;
    check_txn(0, 24'h000040, 16'h0, 2'b11, 0, 0);
    $display("txn abort-then-read adr=000040 acks=%0d", n_ack);

    // Reset during the wait of a 4-burst read.
    gnt_wait_max = 0; rv_min = 5; rv_max = 5;
    @(posedge clk); #1;
    wb_cyc = 1; wb_stb = 1; wb_adr = 24'h000500; wb_4_burst = 1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 0;
    #1;
    check("mid_rst_ack", wb_ack, 0);
    check("mid_rst_err", wb_err, 0);
    check("mid_rst_req", mem_req, 0);
    check("mid_rst_odat", wb_o_dat, 0);
    idle_bus();
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1;
    ack_seen = 0;
    for (int c = 0; c < 8; c++) begin
      #2;
      if (wb_ack || wb_err || mem_req) ack_seen++;
      @(posedge clk); #1;
    end
    check("post_rst_quiet", ack_seen, 0);
    rv_min = 1; rv_max = 2;
    check_txn(0, 24'h000500, 16'h0, 2'b11, 0, 0);

    // Randomized transactions.
    for (int k = 0; k < 40; k++) begin
      r_we = ($urandom_range(9, 0) < 3);
      r_b4 = ($urandom_range(3, 0) == 0);
      r_b8 = ($urandom_range(3, 0) == 0);
      if (r_we && $urandom_range(4, 0) != 0) begin r_b4 = 0; r_b8 = 0; end
      if ($urandom_range(4, 0) == 0) r_adr = 24'(MEM_WORDS - int'($urandom_range(10, 1)));
      else r_adr = 24'h000600 + 24'($urandom_range(31, 0));
      gnt_wait_max = int'($urandom_range(3, 0));
      rv_min = 1;
      rv_max = int'($urandom_range(4, 1));
      check_txn(r_we, r_adr, 16'($urandom), 2'($urandom_range(3, 1)), r_b4, r_b8);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
